// File: rtl/seg7_reader.sv
// Recovers a 3-bit digit from an asynchronous 7-segment drive pattern.
// Path: 2-flop synchronizer -> stability filter -> encoder -> valid/ready output.
module seg7_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  output logic [2:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err_pulse,
  output logic [7:0] err_cnt,
  output logic       overrun,
  input  logic       clr_ovr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [6:0] sync1;
  logic [6:0] seg_s;
  logic [6:0] seg_last;
  logic [7:0] cnt;
  logic [1:0] state;

  logic       changed;
  logic       accept;
  logic       code_legal;
  logic       code_blank;
  logic [2:0] code_val;
  logic       acc_legal;
  logic       acc_illegal;
  logic       xfer;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 7'h00;
      seg_s <= 7'h00;
    end else begin
      sync1 <= seg_in;
      seg_s <= sync1;
    end
  end

  assign changed = (seg_s != seg_last);
  assign accept  = (state == ST_TRACK) && !changed && (cnt == CNT_LAST);

  // Any change restarts the filter; an unchanged pattern in LOCKED never re-fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_last <= 7'h00;
      cnt      <= 8'd0;
      state    <= ST_IDLE;
    end else if (changed) begin
      seg_last <= seg_s;
      cnt      <= 8'd0;
      state    <= ST_TRACK;
    end else begin
      case (state)
        ST_IDLE:   state <= ST_IDLE;
        ST_TRACK: begin
          if (cnt == CNT_LAST) state <= ST_LOCKED;
          else                 cnt   <= cnt + 8'd1;
        end
        ST_LOCKED: state <= ST_LOCKED;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a value unassigned and infer a latch.
  always_comb begin
    code_legal = 1'b0;
    code_blank = 1'b0;
    code_val   = 3'd0;
    case (seg_last)
      7'h3F: begin code_legal = 1'b1; code_val = 3'd0; end
      7'h06: begin code_legal = 1'b1; code_val = 3'd1; end
      7'h5B: begin code_legal = 1'b1; code_val = 3'd2; end
      7'h4F: begin code_legal = 1'b1; code_val = 3'd3; end
      7'h66: begin code_legal = 1'b1; code_val = 3'd4; end
      7'h6D: begin code_legal = 1'b1; code_val = 3'd5; end
      7'h7D: begin code_legal = 1'b1; code_val = 3'd6; end
      7'h07: begin code_legal = 1'b1; code_val = 3'd7; end
      7'h00: code_blank = 1'b1;
      default: ;
    endcase
  end

  assign acc_legal   = accept && code_legal;
  assign acc_illegal = accept && !code_legal && !code_blank;
  assign xfer        = out_valid && out_ready;

  // A new event on a transfer edge replaces the consumed one without overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= 3'd0;
      out_valid <= 1'b0;
    end else if (acc_legal) begin
      out_data  <= code_val;
      out_valid <= 1'b1;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      err_pulse <= acc_illegal;
      if (acc_illegal && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Setting takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  overrun <= 1'b0;
    else if (acc_legal && out_valid && !out_ready) overrun <= 1'b1;
    else if (clr_ovr)                            overrun <= 1'b0;
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: run-length reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_seg7_reader;

  localparam int STABLE = 4;
  localparam int LAT    = STABLE + 3;  // posedges from driving seg_in to the accept edge

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = 7'h00;
  logic       out_ready = 1'b0;
  logic       clr_ovr = 1'b0;
  logic [2:0] out_data;
  logic       out_valid;
  logic       err_pulse;
  logic [7:0] err_cnt;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;
  bit log_en   = 1'b0;
  int xq[$];

  logic [6:0] code_tab [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

  seg7_reader #(.STABLE_CYCLES(STABLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Returns the digit for a legal code, -1 for blank, -2 for anything else.
  function automatic int decode(input logic [6:0] p);
    if (p == 7'h00) return -1;
    for (int i = 0; i < 8; i++) if (code_tab[i] == p) return i;
    return -2;
  endfunction

  // Reference model: an episode is a run of identical samples seen by the filter;
  // the accept happens once, when the run reaches STABLE+1 samples.
  logic [6:0] m_s1 = 7'h00, m_s2 = 7'h00, m_last = 7'h00, m_v;
  int m_run = 0, m_data = 0, m_cnt = 0, m_d;
  bit m_fired = 1'b1, m_valid = 1'b0, m_err = 1'b0, m_ovr = 1'b0, m_acc;

  task automatic model_step();
    if (!rst_n) begin
      m_s1 = 7'h00; m_s2 = 7'h00; m_last = 7'h00;
      m_run = 0; m_fired = 1'b1;
      m_valid = 1'b0; m_data = 0; m_err = 1'b0; m_cnt = 0; m_ovr = 1'b0;
    end else begin
      m_v  = m_s2;
      m_s2 = m_s1;
      m_s1 = seg_in;
      m_acc = 1'b0;
      if (m_v != m_last) begin
        m_last = m_v; m_run = 1; m_fired = 1'b0;
      end else if (!m_fired) begin
        m_run++;
      end
      if (!m_fired && m_run == STABLE + 1) begin
        m_acc = 1'b1; m_fired = 1'b1;
      end
      m_d   = m_acc ? decode(m_last) : -1;
      m_err = (m_acc && m_d == -2);
      if (m_err && m_cnt < 255) m_cnt++;
      if (m_acc && m_d >= 0) begin
        if (m_valid && !out_ready) m_ovr = 1'b1;
        else if (clr_ovr)          m_ovr = 1'b0;
        m_data = m_d; m_valid = 1'b1;
      end else begin
        if (m_valid && out_ready) m_valid = 1'b0;
        if (clr_ovr) m_ovr = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("cmp out_valid", out_valid, m_valid);
      check("cmp out_data",  out_data,  m_data);
      check("cmp err_pulse", err_pulse, m_err);
      check("cmp err_cnt",   err_cnt,   m_cnt);
      check("cmp overrun",   overrun,   m_ovr);
    end
    if (log_en && out_valid && out_ready) xq.push_back(out_data);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step(2);
    check("reset out_valid", out_valid, 0);
    check("reset out_data",  out_data,  0);
    check("reset err_pulse", err_pulse, 0);
    check("reset err_cnt",   err_cnt,   0);
    check("reset overrun",   overrun,   0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    step(2);

    // Constant 0x5B: event exactly on the accept edge.
    seg_in = 7'h5B;
    step(LAT - 1);
    check("t1 valid before", out_valid, 0);
    step(1);
    check("t1 valid", out_valid, 1);
    check("t1 data", out_data, 2);
    check("t1 err_cnt", err_cnt, 0);
    check("t1 overrun", overrun, 0);

    out_ready = 1'b1; step(1); out_ready = 1'b0;
    check("t2 drained", out_valid, 0);

    // One-cycle glitch restarts the filter.
    seg_in = 7'h66;
    step(3);
    seg_in = 7'h67;
    step(1);
    seg_in = 7'h66;
    step(LAT - 1);
    check("t2 valid before", out_valid, 0);
    step(1);
    check("t2 valid", out_valid, 1);
    check("t2 data", out_data, 4);

    // Illegal pattern: single error pulse, pending data untouched.
    seg_in = 7'h12;
    step(LAT - 1);
    check("t3 pulse before", err_pulse, 0);
    step(1);
    check("t3 pulse", err_pulse, 1);
    check("t3 err_cnt", err_cnt, 1);
    check("t3 data kept", out_data, 4);
    check("t3 valid kept", out_valid, 1);
    step(1);
    check("t3 pulse after", err_pulse, 0);
    for (int i = 0; i < 256; i++) begin
      seg_in = 7'h00; step(8);
      seg_in = 7'h12; step(8);
    end
    check("t3 err_cnt sat", err_cnt, 255);

    out_ready = 1'b1; step(1); out_ready = 1'b0;
    seg_in = 7'h00; step(8);
    seg_in = 7'h06; step(8);
    check("t4 first data", out_data, 1);
    check("t4 first ovr", overrun, 0);
    seg_in = 7'h00; step(8);
    seg_in = 7'h07; step(8);
    check("t4 second data", out_data, 7);
    check("t4 overrun", overrun, 1);
    clr_ovr = 1'b1; step(1); clr_ovr = 1'b0;
    check("t4 cleared", overrun, 0);

    // clr_ovr on the same edge as a new overrun: set wins.
    seg_in = 7'h00; step(8);
    seg_in = 7'h3F; step(LAT - 1);
    clr_ovr = 1'b1; step(1); clr_ovr = 1'b0;
    check("t4 set wins", overrun, 1);
    check("t4 set wins data", out_data, 0);
    clr_ovr = 1'b1; step(1); clr_ovr = 1'b0;
    check("t4 recleared", overrun, 0);

    // Transfer and accept on the same edge.
    seg_in = 7'h00; step(8);
    seg_in = 7'h4F; step(LAT - 1);
    out_ready = 1'b1; step(1);
    check("t5 same-edge valid", out_valid, 1);
    check("t5 same-edge data", out_data, 3);
    check("t5 same-edge ovr", overrun, 0);
    step(1);
    check("t5 drained", out_valid, 0);

    // Sweep all codes with the consumer always ready.
    seg_in = 7'h00; step(8);
    log_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      seg_in = code_tab[i]; step(8);
      seg_in = 7'h00;       step(8);
    end
    log_en = 1'b0;
    check("t5 xfer count", xq.size(), 8);
    for (int i = 0; i < 8 && i < xq.size(); i++) check("t5 xfer value", xq[i], i);
    check("t5 no overrun", overrun, 0);

    // Reset mid-TRACK with a pending event.
    out_ready = 1'b0;
    seg_in = 7'h7D; step(8);
    check("t6 pending", out_valid, 1);
    check("t6 pending data", out_data, 6);
    seg_in = 7'h6D; step(4);
    rst_n = 1'b0;
    #1;
    check("t6 rst valid", out_valid, 0);
    check("t6 rst data", out_data, 0);
    check("t6 rst err_cnt", err_cnt, 0);
    check("t6 rst overrun", overrun, 0);
    check("t6 rst pulse", err_pulse, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(LAT - 1);
    check("t6 valid before", out_valid, 0);
    step(1);
    check("t6 reacquired", out_valid, 1);
    check("t6 reacquired data", out_data, 5);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
